// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - shared types and header field positions for the rx command assembler
package rx_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        HOLD    = 2'd2,
        ERR     = 2'd3
    } rx_cmd_state_t;

    localparam int HDR_OP_MSB  = 7;
    localparam int HDR_OP_LSB  = 4;
    localparam int HDR_LEN_MSB = 3;
    localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter with a rollover strobe
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   clear          synchronous clear to 0 (wins over count_enable)
//   count_enable   advance the count this cycle
//   rollover_val   terminal count; the counter wraps to 0 after it
//   rollover_flag  high in the cycle whose increment lands on rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= (count == rollover_val) ? '0 : count + 1'b1;
        end
    end

    // Flags on the increment that reaches rollover_val, so a consumer can act on
    // the same edge the count gets there instead of one cycle later.
    assign rollover_flag = count_enable && !clear && ((count + 1'b1) == rollover_val);

endmodule

// File: rtl/rx_cmd_assembler.sv
// rtl/rx_cmd_assembler.sv - pops rx_fifo bytes and assembles framed GPU commands
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset
//   fifo_empty      rx_fifo empty flag
//   fifo_r_data     rx_fifo head byte (first-word fall-through)
//   fifo_r_enable   pop strobe; a byte is consumed on each rising edge it is high
//   cmd_valid       command outputs valid (held until cmd_ready)
//   cmd_ready       decoder accepts the command
//   cmd_opcode      header[7:4]
//   cmd_len         header[3:0], payload byte count
//   cmd_payload     byte i at [8*i +: 8]; bytes at or above cmd_len read 0
//   frame_err       one-cycle pulse when a frame is discarded
//   busy            state is not IDLE
module rx_cmd_assembler
    import rx_cmd_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     fifo_empty,
    input  logic [7:0]               fifo_r_data,
    output logic                     fifo_r_enable,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [3:0]               cmd_opcode,
    output logic [3:0]               cmd_len,
    output logic [8*MAX_PAYLOAD-1:0] cmd_payload,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_ROLLOVER = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       MAX_LEN      = 4'(MAX_PAYLOAD);

    rx_cmd_state_t            state, state_next;
    logic [IDX_W-1:0]         idx, idx_next;
    logic [3:0]               opcode, opcode_next;
    logic [3:0]               len, len_next;
    logic [8*MAX_PAYLOAD-1:0] payload, payload_next;

    logic       pop;
    logic       last_byte;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;
    logic [3:0] hdr_op;
    logic [3:0] hdr_len;

    assign hdr_op  = fifo_r_data[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_len = fifo_r_data[HDR_LEN_MSB:HDR_LEN_LSB];

    // Only IDLE and PAYLOAD consume bytes; HOLD leaves data in the FIFO so it
    // back-pressures the UART while the decoder is busy.
    assign pop = !fifo_empty && ((state == IDLE) || (state == PAYLOAD));

    // The byte being popped now is the final payload byte of the frame.
    assign last_byte = (32'(idx) + 32'd1) == 32'(len);

    // Stall timer: counts consecutive empty cycles inside a payload and restarts
    // on every pop or whenever the frame is not in its payload phase.
    assign tmo_enable = (state == PAYLOAD) && fifo_empty;
    assign tmo_clear  = pop || (state != PAYLOAD);

    flex_counter #(
        .NUM_CNT_BITS (TMO_W)
    ) u_timeout (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (tmo_clear),
        .count_enable  (tmo_enable),
        .rollover_val  (TMO_ROLLOVER),
        .rollover_flag (tmo_expired)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            idx     <= '0;
            opcode  <= '0;
            len     <= '0;
            payload <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            opcode  <= opcode_next;
            len     <= len_next;
            payload <= payload_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        opcode_next  = opcode;
        len_next     = len;
        payload_next = payload;

        case (state)
            IDLE: begin
                if (pop) begin
                    opcode_next  = hdr_op;
                    len_next     = hdr_len;
                    payload_next = '0;
                    idx_next     = '0;
                    if (hdr_len == 4'd0) begin
                        state_next = HOLD;
                    end else if (hdr_len > MAX_LEN) begin
                        state_next = ERR;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                if (pop) begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (idx == IDX_W'(i)) begin
                            payload_next[8*i +: 8] = fifo_r_data;
                        end
                    end
                    idx_next = idx + 1'b1;
                    if (last_byte) begin
                        state_next = HOLD;
                    end
                end else if (tmo_expired) begin
                    state_next = ERR;
                end
            end

            HOLD: begin
                if (cmd_ready) begin
                    state_next = IDLE;
                end
            end

            ERR: begin
                payload_next = '0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign fifo_r_enable = pop;
    assign cmd_valid     = (state == HOLD);
    assign frame_err     = (state == ERR);
    assign busy          = (state != IDLE);
    assign cmd_opcode    = opcode;
    assign cmd_len       = len;
    assign cmd_payload   = payload;

endmodule
